// File: rtl/uart_defs.sv
// Shared UART definitions for the transmitter and receiver.
//   tx_state_t  : transmitter FSM state encoding
//   START_BIT   : line level of the start bit
//   STOP_BIT    : line level of the stop bit (also the idle level)
//   bit_cycles(): clock cycles per serial bit (integer division)
package uart_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Callers must keep the result >= 2 so each bit has a measurable width.
  function automatic int unsigned bit_cycles(input int unsigned clk_hz,
                                             input int unsigned sclk_hz);
    return clk_hz / sclk_hz;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous single-clock FIFO with registered status outputs.
//   clk, reset     : clock, asynchronous active-high reset
//   we, wdata      : push request and data (ignored while full)
//   re             : pop request (ignored while empty)
//   rdata          : entry at the read pointer (valid while not empty)
//   full, empty    : registered occupancy flags
//   count          : registered occupancy, 0 .. 2**DEPTH
//   overflow       : sticky, set by a push attempted while full
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [DEPTH:0]   count,
  output logic             overflow
);

  localparam int ENTRIES = 1 << DEPTH;

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [DEPTH-1:0] wr_ptr;
  logic [DEPTH-1:0] rd_ptr;
  logic [DEPTH:0]   count_next;
  logic             push;
  logic             pop;

  // Flags are evaluated before the edge, so a push while full is rejected
  // even when a pop happens on the same edge.
  assign push  = we & ~full;
  assign pop   = re & ~empty;
  assign rdata = mem[rd_ptr];

  always_comb begin
    // NOTE: default assignment first so every path drives count_next and no latch is inferred.
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (DEPTH+1)'(1);
      2'b01:   count_next = count - (DEPTH+1)'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: storage has no reset; resetting the pointers is enough to discard its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH'(1);
      count    <= count_next;
      full     <= (count_next == (DEPTH+1)'(ENTRIES));
      empty    <= (count_next == '0);
      overflow <= overflow | (we & full);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte-buffered 8N1 UART transmitter.
//   clk, reset : clock, asynchronous active-high reset
//   we, data_in: enqueue data_in when we=1 and full=0
//   full, empty, count, overflow : FIFO status (registered, overflow sticky)
//   busy       : a frame is being shifted out
//   txd        : serial line, idle high
// The FSM pops the next byte from IDLE, or straight out of the last stop-bit
// cycle, so queued frames follow each other with no idle gap.
module uart_tx_fifo
  import uart_defs::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned SCLK_HZ = 115200,
  parameter int          WIDTH   = 8,
  parameter int          DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [DEPTH:0]   count,
  output logic             overflow,
  output logic             busy,
  output logic             txd
);

  localparam int unsigned BIT_CYCLES = bit_cycles(CLK_HZ, SCLK_HZ);
  localparam int          CW         = $clog2(BIT_CYCLES);
  localparam int          BW         = $clog2(WIDTH + 1);

  tx_state_t        state;
  logic [CW-1:0]    cyc_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] rd_data;
  logic             bit_done;
  logic             pop;

  assign bit_done = (cyc_cnt == CW'(BIT_CYCLES - 1));
  assign pop      = ~empty & ((state == IDLE) | ((state == STOP) & bit_done));

  uart_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .wdata    (data_in),
    .re       (pop),
    .rdata    (rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      txd     <= STOP_BIT;
      busy    <= 1'b0;
      shift   <= '0;
      cyc_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift   <= rd_data;
            txd     <= START_BIT;
            busy    <= 1'b1;
            cyc_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            txd     <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            state   <= DATA;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cyc_cnt <= '0;
            if (bit_cnt == BW'(WIDTH - 1)) begin
              txd   <= STOP_BIT;
              state <= STOP;
            end else begin
              txd     <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            cyc_cnt <= '0;
            if (pop) begin
              shift <= rd_data;
              txd   <= START_BIT;
              state <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        default: begin
          txd   <= STOP_BIT;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo at BIT_CYCLES = 10.
// A line monitor decodes frames at mid-bit into rx_q; directed sequences
// check latency, framing, back-to-back bursts, overflow, wrap and reset.
module tb_uart_tx_fifo;

  localparam int BC = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       we = 1'b0;
  logic [7:0] data_in = '0;
  logic       full, empty, overflow, busy, txd;
  logic [4:0] count;

  int checks = 0;
  int failures = 0;
  int rx_errs = 0;
  logic [7:0] rx_q [$];

  uart_tx_fifo #(
    .CLK_HZ  (50000000),
    .SCLK_HZ (5000000),
    .WIDTH   (8),
    .DEPTH   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .data_in  (data_in),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Line monitor: k=0 is the first negedge seeing the start bit; bit b is
  // sampled at k = 10*b + 4. A reset anywhere in the frame abandons it.
  initial begin
    logic [9:0] f;
    logic       ok;
    forever begin
      @(negedge clk);
      if (!reset && txd == 1'b0) begin
        ok = 1'b1;
        f  = '0;
        f[0] = 1'b0;
        for (int k = 1; k <= 94; k++) begin
          @(negedge clk);
          if (reset) begin
            ok = 1'b0;
            break;
          end
          if (k % 10 == 4) f[k / 10] = txd;
        end
        if (ok) begin
          if (f[0] == 1'b0 && f[9] == 1'b1) rx_q.push_back(f[8:1]);
          else rx_errs++;
        end
      end
    end
  end

  // Single-cycle push; returns at the negedge after the capturing edge.
  task automatic push(input logic [7:0] d);
    we = 1'b1;
    data_in = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (!(busy == 1'b0 && empty == 1'b1) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", (n < bound) ? 32'd1 : 32'd0, 32'd1);
    repeat (10) @(negedge clk);
  endtask

  task automatic check_rx(input string name, input logic [7:0] first, input int n);
    check({name, "_rx_count"}, rx_q.size(), n);
    for (int i = 0; i < n && rx_q.size() > 0; i++)
      check({name, "_rx_byte"}, rx_q.pop_front(), first + 8'(i));
    rx_q.delete();
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // frame[0] = start bit ... frame[9] = stop bit
  } vec_t;

  vec_t vecs [5];

  initial begin
    int run;
    int lows;
    int maxc;
    int n;

    vecs[0] = '{8'h41, 10'b1_0100_0001_0};
    vecs[1] = '{8'h00, 10'b1_0000_0000_0};
    vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
    vecs[3] = '{8'hA5, 10'b1_1010_0101_0};
    vecs[4] = '{8'h0F, 10'b1_0000_1111_0};

    // Reset state
    #12;
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single frames: latency, bit timing, busy width
    foreach (vecs[v]) begin
      push(vecs[v].data);
      check("lat_empty_after_write", empty, 0);
      check("lat_count_after_write", count, 1);
      check("lat_txd_still_idle", txd, 1);
      check("lat_busy_still_low", busy, 0);
      @(negedge clk);                       // k=0: popped, start bit on line
      check("lat_txd_start", txd, 0);
      check("lat_busy_high", busy, 1);
      check("lat_empty_after_pop", empty, 1);
      repeat (4) @(negedge clk);            // k=4
      for (int b = 0; b < 10; b++) begin
        check($sformatf("frame_%0h_bit%0d", vecs[v].data, b), txd, vecs[v].frame[b]);
        if (b < 9) repeat (BC) @(negedge clk);
      end
      repeat (5) @(negedge clk);            // k=99: last frame cycle
      check("frame_busy_last_cycle", busy, 1);
      @(negedge clk);                       // k=100
      check("frame_busy_dropped", busy, 0);
      check("frame_txd_idle", txd, 1);
      check("frame_rx_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check("frame_rx_byte", rx_q.pop_front(), vecs[v].data);
      rx_q.delete();
      repeat (3) @(negedge clk);
    end

    // Burst "Hi!" on consecutive edges: back-to-back frames, no idle gap
    we = 1'b1;
    data_in = 8'h48; @(negedge clk);
    data_in = 8'h69; @(negedge clk);
    data_in = 8'h21; @(negedge clk);
    we = 1'b0;
    // The first byte is popped on the edge after its write.
    check("burst_count_peak", count, 2);
    run = 0;
    n = 0;
    while (busy && n < 400) begin
      run++;
      n++;
      @(negedge clk);
    end
    // Busy spans 300 negedges; the first one passed before counting began.
    check("burst_busy_run", run, 299);
    wait_idle(50);
    check("burst_rx_count", rx_q.size(), 3);
    if (rx_q.size() > 0) check("burst_rx0", rx_q.pop_front(), 8'h48);
    if (rx_q.size() > 0) check("burst_rx1", rx_q.pop_front(), 8'h69);
    if (rx_q.size() > 0) check("burst_rx2", rx_q.pop_front(), 8'h21);
    rx_q.delete();

    // Overflow: 18 consecutive writes while the first frame runs
    we = 1'b1;
    for (int i = 0; i < 18; i++) begin
      data_in = 8'(i);
      @(negedge clk);
      if (i == 16) begin
        check("ovf_full_at_16", full, 1);
        check("ovf_count_at_16", count, 16);
        check("ovf_not_yet", overflow, 0);
      end
    end
    we = 1'b0;
    check("ovf_full", full, 1);
    check("ovf_count_held", count, 16);
    check("ovf_set", overflow, 1);
    wait_idle(17 * 100 + 50);
    check("ovf_sticky", overflow, 1);
    check_rx("ovf", 8'h00, 17);

    // Paced writes wrap the pointers; occupancy never exceeds 1
    maxc = 0;
    for (int i = 0; i < 20; i++) begin
      push(8'h80 + 8'(i));
      if (int'(count) > maxc) maxc = int'(count);
      n = 0;
      while (!empty && n < 200) begin
        @(negedge clk);
        if (int'(count) > maxc) maxc = int'(count);
        n++;
      end
      check("pace_pop_timeout", (n < 200) ? 32'd1 : 32'd0, 32'd1);
    end
    wait_idle(300);
    check("pace_max_count", maxc, 1);
    check_rx("pace", 8'h80, 20);

    // Reset during data bit 3 of 0x55 with two bytes queued
    we = 1'b1;
    data_in = 8'h55; @(negedge clk);
    data_in = 8'h12; @(negedge clk);
    data_in = 8'h34; @(negedge clk);
    we = 1'b0;                              // now at k=1 of the 0x55 frame
    repeat (43) @(negedge clk);             // k=44: middle of data bit 3
    check("abort_bit3_low", txd, 0);
    check("abort_count_before", count, 2);
    reset = 1'b1;
    #1;
    check("abort_txd_async", txd, 1);
    check("abort_count", count, 0);
    check("abort_empty", empty, 1);
    check("abort_busy", busy, 0);
    check("abort_overflow_cleared", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (txd == 1'b0 || busy == 1'b1) lows++;
    end
    check("abort_no_more_frames", lows, 0);
    check("abort_rx_empty", rx_q.size(), 0);
    rx_q.delete();

    // Push on the same edge as a STOP-end pop with count=5
    we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = 8'h60 + 8'(i);
      @(negedge clk);
    end
    we = 1'b0;                              // k=4 of first frame
    check("pp_count_before", count, 5);
    repeat (95) @(negedge clk);             // k=99: next edge pops
    we = 1'b1;
    data_in = 8'h66;
    @(negedge clk);
    we = 1'b0;
    check("pp_count_same", count, 5);
    check("pp_next_start", txd, 0);
    wait_idle(7 * 100 + 50);
    check_rx("pp", 8'h60, 7);

    check("rx_frame_errors", rx_errs, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit in case a wait is mis-bounded.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
